parity_gen: RTL and testbench

//  Write-side parity generator for raw hits RAMs: 30 CFEB (5 cfebs x 6 layers), 5 RPC and 2 miniscope.

---
 rtl/parity_gen_pkg.sv | 31 +++
 rtl/parity_gen_bit.sv | 23 ++
 rtl/parity_gen.sv | 191 +++++++++++++++++++
 tb/tb_parity_gen.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/parity_gen_pkg.sv
// Shared constants for the raw-hits RAM write-side parity generator:
// data widths, RAM index map and the two-state sweep/run encoding.
package parity_gen_pkg;

  localparam int MXCFEB   = 5;   // CFEBs on CSC
  localparam int MXLY     = 6;   // layers per CFEB
  localparam int MXDS     = 8;   // data bits per CFEB layer RAM
  localparam int MXRPC    = 5;   // RPC RAMs
  localparam int RPC_DW   = 16;  // data bits per RPC RAM
  localparam int MINI_DW  = 18;  // data bits per miniscope RAM
  localparam int NMINI    = 2;   // miniscope RAMs
  localparam int RAM_ADRB = 11;  // RAM address width (depth 2048)

  localparam int NRAM     = MXCFEB * MXLY + MXRPC + NMINI;  // 37 RAMs

  // Index of the first RAM of each group within ram_par
  localparam int CFEB_RAM0 = 0;
  localparam int RPC_RAM0  = 30;
  localparam int MINI_RAM0 = 35;

  localparam int CFEB_W = MXCFEB * MXLY * MXDS;
  localparam int RPC_W  = MXRPC * RPC_DW;
  localparam int MINI_W = NMINI * MINI_DW;
  localparam int INJ_W  = 6;  // width of an injection RAM index

  typedef enum logic {
    S_INIT = 1'b0,  // post-reset address sweep writing parity-valid zeros
    S_RUN  = 1'b1   // normal pass-through of sequencer writes
  } state_t;

endpackage

// File: rtl/parity_gen_bit.sv
// One registered odd-parity bit for a single RAM of width W.
// The flip input inverts the stored bit to deliberately corrupt one write.
module parity_gen_bit #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] data,
  input  logic         flip,
  output logic         par
);

  // Capture odd parity of the incoming word whenever its data register loads
  always_ff @(posedge clock) begin
    if (reset) begin
      par <= 1'b0;
    end else if (load) begin
      par <= ~(^data) ^ flip;
    end
  end

endmodule

// File: rtl/parity_gen.sv
// Write-side parity generator for the 37 raw-hits RAMs (30 CFEB, 5 RPC, 2 mini).
// After reset it sweeps every address with zero data and valid parity, then
// forwards sequencer writes with one clock of latency.
// Optional feature: define PARITY_INJECT_EN to add the parity-corruption
// injection ports (inject_req/inject_ram/inject_ack/inject_bad).
module parity_gen
  import parity_gen_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                fifo_wen_in,
  input  logic [CFEB_W-1:0]   cfeb_wdata_in,
  input  logic [RPC_W-1:0]    rpc_wdata_in,
  input  logic [MINI_W-1:0]   mini_wdata_in,
  output logic                ram_wen,
  output logic [RAM_ADRB-1:0] ram_wadr,
  output logic [CFEB_W-1:0]   cfeb_wdata,
  output logic [RPC_W-1:0]    rpc_wdata,
  output logic [MINI_W-1:0]   mini_wdata,
  output logic [NRAM-1:0]     ram_par,
  output logic                init_busy,
  output logic                init_done
`ifdef PARITY_INJECT_EN
  ,
  input  logic                inject_req,
  input  logic [INJ_W-1:0]    inject_ram,
  output logic                inject_ack,
  output logic                inject_bad
`endif
);

  state_t              state_reg, state_next;
  logic                run;
  logic                sweep_last;
  logic                load;
  logic                ram_wen_next;
  logic [RAM_ADRB-1:0] wadr_next;
  logic [CFEB_W-1:0]   cfeb_d;
  logic [RPC_W-1:0]    rpc_d;
  logic [MINI_W-1:0]   mini_d;
  logic [NRAM-1:0]     flip;

  assign run        = (state_reg == S_RUN);
  // Last sweep address is currently on the write port
  assign sweep_last = !run && ram_wen && (ram_wadr == {RAM_ADRB{1'b1}});
  // The sweep loads zeros every clock; in run mode only requested writes load
  assign load       = !run || fifo_wen_in;
  assign cfeb_d     = run ? cfeb_wdata_in : '0;
  assign rpc_d      = run ? rpc_wdata_in  : '0;
  assign mini_d     = run ? mini_wdata_in : '0;

  assign init_busy  = !run;
  assign init_done  = run;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= S_INIT;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state, next write enable and next write address
  always_comb begin
    state_next   = state_reg;
    ram_wen_next = 1'b0;
    wadr_next    = ram_wadr;
    case (state_reg)
      S_INIT: begin
        ram_wen_next = !sweep_last;
        if (sweep_last) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        ram_wen_next = fifo_wen_in;
      end
      default: begin
        state_next = S_INIT;
      end
    endcase
    // Address advances the clock after each write; wraps naturally at 2047
    if (ram_wen) begin
      wadr_next = ram_wadr + RAM_ADRB'(1);
    end
  end

  // Write enable and address registers
  always_ff @(posedge clock) begin
    if (reset) begin
      ram_wen  <= 1'b0;
      ram_wadr <= '0;
    end else begin
      ram_wen  <= ram_wen_next;
      ram_wadr <= wadr_next;
    end
  end

  // Write data registers, zeroed during the sweep and held when idle
  always_ff @(posedge clock) begin
    if (reset) begin
      cfeb_wdata <= '0;
      rpc_wdata  <= '0;
      mini_wdata <= '0;
    end else if (load) begin
      cfeb_wdata <= cfeb_d;
      rpc_wdata  <= rpc_d;
      mini_wdata <= mini_d;
    end
  end

`ifdef PARITY_INJECT_EN
  logic             pending_reg;
  logic [INJ_W-1:0] pending_ram_reg;
  logic             ack_reg;
  logic             bad_reg;
  logic             inj_fire;
  logic             req_ok;

  // The pending corruption is applied to the next run-mode write
  assign inj_fire   = run && fifo_wen_in && pending_reg;
  // New requests are taken only in run mode with nothing already pending
  assign req_ok     = run && inject_req && !pending_reg;
  assign inject_ack = ack_reg;
  assign inject_bad = bad_reg;

  // Injection request latch and single-clock acknowledge
  always_ff @(posedge clock) begin
    if (reset) begin
      pending_reg     <= 1'b0;
      pending_ram_reg <= '0;
      ack_reg         <= 1'b0;
      bad_reg         <= 1'b0;
    end else begin
      ack_reg <= 1'b0;
      bad_reg <= 1'b0;
      if (inj_fire) begin
        pending_reg <= 1'b0;
        ack_reg     <= 1'b1;
      end else if (req_ok) begin
        if (inject_ram >= INJ_W'(NRAM)) begin
          ack_reg <= 1'b1;
          bad_reg <= 1'b1;
        end else begin
          pending_reg     <= 1'b1;
          pending_ram_reg <= inject_ram;
        end
      end
    end
  end
`endif

  // One parity bit per RAM, sliced from the group that RAM belongs to
  for (genvar gi = 0; gi < NRAM; gi++) begin : g_par
`ifdef PARITY_INJECT_EN
    assign flip[gi] = inj_fire && (pending_ram_reg == INJ_W'(gi));
`else
    assign flip[gi] = 1'b0;
`endif
    if (gi < RPC_RAM0) begin : g_cfeb
      parity_gen_bit #(.W(MXDS)) u_bit (
        .clock (clock),
        .reset (reset),
        .load  (load),
        .data  (cfeb_d[(gi - CFEB_RAM0) * MXDS +: MXDS]),
        .flip  (flip[gi]),
        .par   (ram_par[gi])
      );
    end else if (gi < MINI_RAM0) begin : g_rpc
      parity_gen_bit #(.W(RPC_DW)) u_bit (
        .clock (clock),
        .reset (reset),
        .load  (load),
        .data  (rpc_d[(gi - RPC_RAM0) * RPC_DW +: RPC_DW]),
        .flip  (flip[gi]),
        .par   (ram_par[gi])
      );
    end else begin : g_mini
      parity_gen_bit #(.W(MINI_DW)) u_bit (
        .clock (clock),
        .reset (reset),
        .load  (load),
        .data  (mini_d[(gi - MINI_RAM0) * MINI_DW +: MINI_DW]),
        .flip  (flip[gi]),
        .par   (ram_par[gi])
      );
    end
  end

endmodule

// File: tb/tb_parity_gen.sv
// Directed self-checking bench for parity_gen: reset sweep, run-mode parity,
// address wrap, mid-sweep reset and (with PARITY_INJECT_EN) injection.
module tb_parity_gen;
  import parity_gen_pkg::*;

  localparam logic [NRAM-1:0] PAR_ONES = 37'h1F_FFFF_FFFF;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                fifo_wen_in = 1'b0;
  logic [CFEB_W-1:0]   cfeb_wdata_in = '0;
  logic [RPC_W-1:0]    rpc_wdata_in = '0;
  logic [MINI_W-1:0]   mini_wdata_in = '0;
  logic                ram_wen;
  logic [RAM_ADRB-1:0] ram_wadr;
  logic [CFEB_W-1:0]   cfeb_wdata;
  logic [RPC_W-1:0]    rpc_wdata;
  logic [MINI_W-1:0]   mini_wdata;
  logic [NRAM-1:0]     ram_par;
  logic                init_busy;
  logic                init_done;
`ifdef PARITY_INJECT_EN
  logic                inject_req = 1'b0;
  logic [INJ_W-1:0]    inject_ram = '0;
  logic                inject_ack;
  logic                inject_bad;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  parity_gen dut (
    .clock         (clock),
    .reset         (reset),
    .fifo_wen_in   (fifo_wen_in),
    .cfeb_wdata_in (cfeb_wdata_in),
    .rpc_wdata_in  (rpc_wdata_in),
    .mini_wdata_in (mini_wdata_in),
    .ram_wen       (ram_wen),
    .ram_wadr      (ram_wadr),
    .cfeb_wdata    (cfeb_wdata),
    .rpc_wdata     (rpc_wdata),
    .mini_wdata    (mini_wdata),
    .ram_par       (ram_par),
    .init_busy     (init_busy),
    .init_done     (init_done)
`ifdef PARITY_INJECT_EN
    ,
    .inject_req    (inject_req),
    .inject_ram    (inject_ram),
    .inject_ack    (inject_ack),
    .inject_bad    (inject_bad)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled on the falling edge
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    int errs;
    int cnt;

    // ---- Test 1: reset state and full address sweep ----
    reset = 1'b1;
    tick();
    tick();
    check("rst_wen",  64'(ram_wen),   64'd0);
    check("rst_wadr", 64'(ram_wadr),  64'd0);
    check("rst_busy", 64'(init_busy), 64'd1);
    check("rst_done", 64'(init_done), 64'd0);
    check("rst_par",  64'(ram_par),   64'd0);
    check("rst_cfeb", 64'(cfeb_wdata[63:0]), 64'd0);
`ifdef PARITY_INJECT_EN
    check("rst_ack",  64'(inject_ack), 64'd0);
    check("rst_bad",  64'(inject_bad), 64'd0);
`endif
    reset = 1'b0;
    fifo_wen_in   = 1'b1;          // must be discarded during the sweep
    cfeb_wdata_in = {CFEB_W{1'b1}};
    errs = 0;
    for (int k = 0; k < 2048; k++) begin
      tick();
      if (ram_wen !== 1'b1 || ram_wadr !== RAM_ADRB'(k) || init_busy !== 1'b1 ||
          init_done !== 1'b0 || ram_par !== PAR_ONES || cfeb_wdata !== '0) errs++;
    end
    $display("sweep: 2048 writes, last address %0d", ram_wadr);
    check("sweep_errs", 64'(errs), 64'd0);
    check("sweep_last_adr", 64'(ram_wadr), 64'd2047);
    check("sweep_par", 64'(ram_par), 64'(PAR_ONES));
    fifo_wen_in   = 1'b0;
    cfeb_wdata_in = '0;
    tick();
    check("done_rise",  64'(init_done), 64'd1);
    check("busy_fall",  64'(init_busy), 64'd0);
    check("done_wadr",  64'(ram_wadr),  64'd0);
    check("done_wen",   64'(ram_wen),   64'd0);

    // ---- Test 2: run-mode parity ----
    fifo_wen_in = 1'b1;
    cfeb_wdata_in[7:0] = 8'h03;
    tick();
    $display("write adr=%0d wen=%0d par=0x%0h", ram_wadr, ram_wen, ram_par);
    check("w1_wen",   64'(ram_wen),    64'd1);
    check("w1_wadr",  64'(ram_wadr),   64'd0);
    check("w1_par0",  64'(ram_par[0]), 64'd1);
    check("w1_par1",  64'(ram_par[1]), 64'd1);
    check("w1_cfeb",  64'(cfeb_wdata[7:0]), 64'h03);
    cfeb_wdata_in[7:0] = 8'h01;
    rpc_wdata_in[2*RPC_DW +: RPC_DW]     = 16'h0007;
    mini_wdata_in[1*MINI_DW +: MINI_DW] = 18'h00003;
    tick();
    $display("write adr=%0d wen=%0d par=0x%0h", ram_wadr, ram_wen, ram_par);
    check("w2_wadr",  64'(ram_wadr), 64'd1);
    check("w2_par",   64'(ram_par),  64'h1E_FFFF_FFFE);
    check("w2_rpc",   64'(rpc_wdata[2*RPC_DW +: RPC_DW]), 64'h0007);
    check("w2_mini",  64'(mini_wdata[1*MINI_DW +: MINI_DW]), 64'h00003);
    // Idle: data and parity hold even though inputs change
    fifo_wen_in   = 1'b0;
    cfeb_wdata_in = '0;
    rpc_wdata_in  = '0;
    mini_wdata_in = '0;
    tick();
    check("idle_wen",  64'(ram_wen),  64'd0);
    check("idle_wadr", 64'(ram_wadr), 64'd2);
    check("idle_par",  64'(ram_par),  64'h1E_FFFF_FFFE);
    check("idle_cfeb", 64'(cfeb_wdata[7:0]), 64'h01);
    tick();
    check("idle2_wadr", 64'(ram_wadr), 64'd2);

    // ---- Test 3: 2049 back-to-back writes wrap the address ----
    fifo_wen_in = 1'b1;
    errs = 0;
    for (int i = 0; i < 2049; i++) begin
      tick();
      if (ram_wen !== 1'b1 || ram_wadr !== RAM_ADRB'((i + 2) % 2048)) errs++;
      if (i == 2045) check("wrap_pre", 64'(ram_wadr), 64'd2047);
      if (i == 2046) check("wrap_zero", 64'(ram_wadr), 64'd0);
    end
    $display("burst: 2049 writes, last address %0d", ram_wadr);
    check("burst_errs", 64'(errs), 64'd0);
    check("burst_par",  64'(ram_par), 64'(PAR_ONES));
    fifo_wen_in = 1'b0;
    tick();

    // ---- Test 4: reset at sweep address 1000 restarts the sweep ----
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 1001; k++) tick();
    check("mid_adr", 64'(ram_wadr), 64'd1000);
    reset = 1'b1;
    tick();
    check("mid_rst_wadr", 64'(ram_wadr),  64'd0);
    check("mid_rst_busy", 64'(init_busy), 64'd1);
    check("mid_rst_wen",  64'(ram_wen),   64'd0);
    reset = 1'b0;
    cnt = 0;
    tick();
    cnt++;
    check("restart_wadr", 64'(ram_wadr), 64'd0);
    check("restart_wen",  64'(ram_wen),  64'd1);
    while (init_done !== 1'b1 && cnt < 3000) begin
      tick();
      cnt++;
    end
    $display("restart: sweep finished after %0d clocks", cnt);
    check("restart_len", 64'(cnt), 64'd2049);

`ifdef PARITY_INJECT_EN
    // ---- Test 5: inject on RAM 31, write three clocks later ----
    inject_req = 1'b1;
    inject_ram = 6'd31;
    tick();
    inject_req = 1'b0;
    check("inj_wait_ack", 64'(inject_ack), 64'd0);
    tick();
    check("inj_wait_ack2", 64'(inject_ack), 64'd0);
    fifo_wen_in = 1'b1;
    tick();
    $display("inject write adr=%0d ack=%0d par=0x%0h", ram_wadr, inject_ack, ram_par);
    check("inj_wen",  64'(ram_wen),    64'd1);
    check("inj_ack",  64'(inject_ack), 64'd1);
    check("inj_bad",  64'(inject_bad), 64'd0);
    check("inj_par",  64'(ram_par),    64'h1F_7FFF_FFFF);
    tick();
    check("inj_next_par", 64'(ram_par),    64'(PAR_ONES));
    check("inj_next_ack", 64'(inject_ack), 64'd0);
    fifo_wen_in = 1'b0;

    // ---- Test 6: out-of-range index, then a request while pending ----
    inject_req = 1'b1;
    inject_ram = 6'd40;
    tick();
    inject_req = 1'b0;
    check("bad_ack", 64'(inject_ack), 64'd1);
    check("bad_bad", 64'(inject_bad), 64'd1);
    check("bad_par", 64'(ram_par),    64'(PAR_ONES));
    tick();
    check("bad_ack_clr", 64'(inject_ack), 64'd0);
    inject_req = 1'b1;
    inject_ram = 6'd3;
    tick();
    inject_ram = 6'd5;               // ignored: RAM 3 still pending
    tick();
    inject_req = 1'b0;
    fifo_wen_in = 1'b1;
    tick();
    $display("inject write adr=%0d ack=%0d par=0x%0h", ram_wadr, inject_ack, ram_par);
    check("pend_par", 64'(ram_par),    64'h1F_FFFF_FFF7);
    check("pend_ack", 64'(inject_ack), 64'd1);
    tick();
    check("pend_next_par", 64'(ram_par),    64'(PAR_ONES));
    check("pend_next_ack", 64'(inject_ack), 64'd0);
    fifo_wen_in = 1'b0;
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
